control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Microcoded control unit for the 8-bit bus CPU.
- Steps a T-state counter through fetch and execute phases and decodes the 4-bit opcode from the instruction register into one-hot control strobes: bus drivers, register loads, ALU output enable, ALU subtract, PC control and halt.
- Samples the registered ALU carry and zero flags for conditional jumps.
- Sits between the instruction register / flag outputs and every bus participant.

Parameters:
- LAST_STEP, 4, index of final T-state; T-states are T0..LAST_STEP. Fixed at 4 for this instruction set; values below 4 are unsupported.

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  run enable; low = stall
- opcode  input  4  instruction register high nibble
- cf  input  1  ALU carry flag (registered)
- zf  input  1  ALU zero flag (registered)
- pc_out  output  1  PC drives bus
- pc_inc  output  1  PC increments at next edge
- pc_load  output  1  PC loads from bus
- mar_in  output  1  MAR loads from bus
- ram_out  output  1  RAM drives bus
- ram_in  output  1  RAM writes from bus
- ir_in  output  1  IR loads from bus
- ir_out  output  1  IR low nibble drives bus
- a_in  output  1  register A loads
- a_out  output  1  register A drives bus
- b_in  output  1  register B loads
- alu_out  output  1  ALU drives bus and updates CF/ZF (ALU enable_output)
- alu_sub  output  1  ALU subtract select
- out_in  output  1  output register loads
- halted  output  1  CPU halted
- step  output  3  current T-state, debug

Behaviour:
- Reset (rst_n low, async): step=0, halted=0; all strobes forced 0 while rst_n is low.
- On the first clk edge after release, the sequencer is in T0.
- Strobes are combinational from (step, opcode, cf, zf, halted, ena).
- ena=0: step holds and all strobes are 0.
- halted=1: step holds at 0 and all strobes are 0 until reset.
- Fetch, every instruction:
  - T0: pc_out, mar_in
  - T1: ram_out, ir_in, pc_inc
- Execute, T2..T4, by opcode:
  - 0x0 NOP: nothing
  - 0x1 LDA: T2 ir_out+mar_in; T3 ram_out+a_in
  - 0x2 ADD: T2 ir_out+mar_in; T3 ram_out+b_in; T4 alu_out+a_in
  - 0x3 SUB: same as ADD, plus alu_sub asserted in T4
  - 0x4 STA: T2 ir_out+mar_in; T3 a_out+ram_in
  - 0x5 LDI: T2 ir_out+a_in
  - 0x6 JMP: T2 ir_out+pc_load
  - 0x7 JC: T2 ir_out+pc_load only if cf=1; otherwise nothing
  - 0x8 JZ: T2 ir_out+pc_load only if zf=1; otherwise nothing
  - 0xE OUT: T2 a_out+out_in
  - 0xF HLT: T2 sets halted at the clk edge ending T2
  - 0x9-0xD: NOP
- Variable length: the final step of each opcode returns to T0 at the next enabled edge.
  - Final step: T2 for NOP, LDI, jumps, OUT, unused opcodes; T3 for LDA, STA; T4 for ADD, SUB.
  - Cycle counts: NOP=3, LDA=4, ADD=5, JMP=3.
  - Step never exceeds LAST_STEP; reaching LAST_STEP forces return to T0.
- Bus exclusivity: at most one of pc_out, ram_out, ir_out, a_out, alu_out is 1 in any cycle.
- alu_sub is only ever 1 together with alu_out.
- Flag timing: CF/ZF update at the edge ending ADD/SUB T4. A JC/JZ in the next instruction's T2 sees the updated value.
- opcode is sampled combinationally each cycle; it is stable from T2 because IR loads at the end of T1.
- Reset mid-instruction: returns to T0 immediately; no partial strobes after rst_n falls.

Test Plan:
- Reset release, ena=1, opcode=0x0 -> step sequence 0,1,2,0,1. T0 has pc_out=mar_in=1; T1 has ram_out=ir_in=pc_inc=1; T2 has all strobes 0.
- opcode=0x3 (SUB) -> 5-cycle instruction. T4 has alu_out=a_in=alu_sub=1; the bus-driver one-hot check holds on every cycle.
- opcode=0x7 with cf=0, then cf=1 -> pc_load=0 in T2 on the first pass; ir_out=pc_load=1 in T2 on the second.
- ena dropped at T3 of ADD for 3 cycles -> step stays 3 and all strobes are 0. After ena returns, T3 (ram_out+b_in) and then T4 proceed.
- opcode=0xF -> halted=1 after T2, step=0, all strobes 0 for 20 cycles. rst_n pulse low clears halted.
- rst_n asserted mid-T3 of LDA -> strobes 0 asynchronously and step=0. After release the first cycle is T0.

Source files
------------

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//
// Microcoded control unit for the 8-bit bus CPU. A T-state counter walks
// through a two-step fetch (T0, T1) and up to three execute steps (T2..T4).
// The 4-bit opcode from the instruction register is decoded into one-hot
// control strobes for every bus participant. Instructions are variable
// length: each opcode's final step returns the counter to T0.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   ena      in   run enable; low stalls the sequencer and blanks strobes
//   opcode   in   [3:0] instruction register high nibble
//   cf, zf   in   registered ALU carry / zero flags (for JC / JZ)
//   pc_out, pc_inc, pc_load          out  program counter control
//   mar_in                           out  MAR load
//   ram_out, ram_in                  out  RAM drive / write
//   ir_in, ir_out                    out  IR load / low nibble drive
//   a_in, a_out, b_in                out  register A/B control
//   alu_out, alu_sub                 out  ALU drive (+flag update), subtract
//   out_in                           out  output register load
//   halted   out  CPU halted (cleared only by reset)
//   step     out  [2:0] current T-state, debug
// ---------------------------------------------------------------------------
module control_sequencer #(
  parameter int LAST_STEP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] opcode,
  input  logic       cf,
  input  logic       zf,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mar_in,
  output logic       ram_out,
  output logic       ram_in,
  output logic       ir_in,
  output logic       ir_out,
  output logic       a_in,
  output logic       a_out,
  output logic       b_in,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       out_in,
  output logic       halted,
  output logic [2:0] step
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_e;

  localparam step_e LAST = step_e'(3'(LAST_STEP));

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  step_e step_q, step_d;
  logic  halted_q, halted_d;
  logic  run;
  logic  last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    last     = 1'b0;
    pc_out   = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    mar_in   = 1'b0;
    ram_out  = 1'b0;
    ram_in   = 1'b0;
    ir_in    = 1'b0;
    ir_out   = 1'b0;
    a_in     = 1'b0;
    a_out    = 1'b0;
    b_in     = 1'b0;
    alu_out  = 1'b0;
    alu_sub  = 1'b0;
    out_in   = 1'b0;
    // rst_n is included so strobes drop the instant reset asserts, even
    // though the counter itself reads as T0 during reset.
    run = rst_n & ena & ~halted_q;

    if (run) begin
      case (step_q)
        T0: begin
          pc_out = 1'b1;
          mar_in = 1'b1;
        end
        T1: begin
          ram_out = 1'b1;
          ir_in   = 1'b1;
          pc_inc  = 1'b1;
        end
        T2: begin
          last = 1'b1;
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ir_out = 1'b1;
              mar_in = 1'b1;
              last   = 1'b0;
            end
            OP_LDI: begin
              ir_out = 1'b1;
              a_in   = 1'b1;
            end
            OP_JMP: begin
              ir_out  = 1'b1;
              pc_load = 1'b1;
            end
            OP_JC: begin
              ir_out  = cf;
              pc_load = cf;
            end
            OP_JZ: begin
              ir_out  = zf;
              pc_load = zf;
            end
            OP_OUT: begin
              a_out  = 1'b1;
              out_in = 1'b1;
            end
            OP_HLT: halted_d = 1'b1;
            default: ;
          endcase
        end
        T3: begin
          last = 1'b1;
          case (opcode)
            OP_LDA: begin
              ram_out = 1'b1;
              a_in    = 1'b1;
            end
            OP_STA: begin
              a_out  = 1'b1;
              ram_in = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ram_out = 1'b1;
              b_in    = 1'b1;
              last    = 1'b0;
            end
            default: ;
          endcase
        end
        default: begin
          // T4 (and any unreachable code) always ends the instruction.
          last = 1'b1;
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_out = 1'b1;
            a_in    = 1'b1;
            alu_sub = (opcode == OP_SUB);
          end
        end
      endcase
      step_d = (last || step_q >= LAST) ? T0 : step_e'(step_q + 3'd1);
    end
  end

  assign halted = halted_q;
  assign step   = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [3:0] opcode;
  logic       cf, zf;
  logic       pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out;
  logic       a_in, a_out, b_in, alu_out, alu_sub, out_in, halted;
  logic [2:0] step;

  control_sequencer #(.LAST_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode), .cf(cf), .zf(zf),
    .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_in(mar_in),
    .ram_out(ram_out), .ram_in(ram_in), .ir_in(ir_in), .ir_out(ir_out),
    .a_in(a_in), .a_out(a_out), .b_in(b_in), .alu_out(alu_out),
    .alu_sub(alu_sub), .out_in(out_in), .halted(halted), .step(step)
  );

  always #5 clk = ~clk;

  // Strobe bit positions in the packed 14-bit word
  localparam logic [13:0] PCO  = 14'h2000;
  localparam logic [13:0] PCI  = 14'h1000;
  localparam logic [13:0] PCL  = 14'h0800;
  localparam logic [13:0] MAR  = 14'h0400;
  localparam logic [13:0] RAMO = 14'h0200;
  localparam logic [13:0] RAMI = 14'h0100;
  localparam logic [13:0] IRI  = 14'h0080;
  localparam logic [13:0] IRO  = 14'h0040;
  localparam logic [13:0] AI   = 14'h0020;
  localparam logic [13:0] AO   = 14'h0010;
  localparam logic [13:0] BI   = 14'h0008;
  localparam logic [13:0] ALUO = 14'h0004;
  localparam logic [13:0] SUBS = 14'h0002;
  localparam logic [13:0] OUTI = 14'h0001;
  localparam logic [13:0] F0   = PCO | MAR;
  localparam logic [13:0] F1   = RAMO | IRI | PCI;

  typedef struct {
    logic        ena;
    logic [3:0]  op;
    logic        cf;
    logic        zf;
    logic [2:0]  exp_step;
    logic [13:0] exp_strb;
    logic        exp_halt;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [13:0] strobes();
    return {pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out,
            a_in, a_out, b_in, alu_out, alu_sub, out_in};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_bus(input string name);
    int drivers;
    drivers = int'(pc_out) + int'(ram_out) + int'(ir_out) + int'(a_out) + int'(alu_out);
    check({name, " bus_onehot"}, (drivers <= 1) ? 1 : 0, 1);
    check({name, " sub_with_alu"}, (alu_sub && !alu_out) ? 1 : 0, 0);
  endtask

  task automatic add(input logic e, input logic [3:0] op, input logic c, input logic z,
                     input logic [2:0] st, input logic [13:0] s);
    vec_t v;
    v.ena = e; v.op = op; v.cf = c; v.zf = z;
    v.exp_step = st; v.exp_strb = s; v.exp_halt = 1'b0;
    vecs.push_back(v);
  endtask

  task automatic fetch(input logic [3:0] op, input logic c, input logic z);
    add(1, op, c, z, 3'd0, F0);
    add(1, op, c, z, 3'd1, F1);
  endtask

  task automatic drive(input logic e, input logic [3:0] op, input logic c, input logic z);
    @(negedge clk);
    ena = e; opcode = op; cf = c; zf = z;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; opcode = 4'h0; cf = 1'b0; zf = 1'b0;

    // Reset state: strobes held off even with ena high
    repeat (2) @(negedge clk);
    #1;
    check("reset step", 32'(step), 0);
    check("reset halted", 32'(halted), 0);
    check("reset strobes", 32'(strobes()), 0);

    // Table: instruction stream, one record per clock
    fetch(4'h0, 0, 0); add(1, 4'h0, 0, 0, 3'd2, 14'h0);                  // NOP
    fetch(4'h1, 0, 0); add(1, 4'h1, 0, 0, 3'd2, IRO | MAR);
                       add(1, 4'h1, 0, 0, 3'd3, RAMO | AI);              // LDA
    fetch(4'h2, 0, 0); add(1, 4'h2, 0, 0, 3'd2, IRO | MAR);
                       add(1, 4'h2, 0, 0, 3'd3, RAMO | BI);
                       add(1, 4'h2, 0, 0, 3'd4, ALUO | AI);              // ADD
    fetch(4'h3, 0, 0); add(1, 4'h3, 0, 0, 3'd2, IRO | MAR);
                       add(1, 4'h3, 0, 0, 3'd3, RAMO | BI);
                       add(1, 4'h3, 0, 0, 3'd4, ALUO | AI | SUBS);       // SUB
    fetch(4'h4, 0, 0); add(1, 4'h4, 0, 0, 3'd2, IRO | MAR);
                       add(1, 4'h4, 0, 0, 3'd3, AO | RAMI);              // STA
    fetch(4'h5, 0, 0); add(1, 4'h5, 0, 0, 3'd2, IRO | AI);               // LDI
    fetch(4'h6, 0, 0); add(1, 4'h6, 0, 0, 3'd2, IRO | PCL);              // JMP
    fetch(4'h7, 0, 0); add(1, 4'h7, 0, 0, 3'd2, 14'h0);                  // JC, no carry
    fetch(4'h7, 1, 0); add(1, 4'h7, 1, 0, 3'd2, IRO | PCL);              // JC, carry
    fetch(4'h8, 1, 0); add(1, 4'h8, 1, 0, 3'd2, 14'h0);                  // JZ, not zero
    fetch(4'h8, 0, 1); add(1, 4'h8, 0, 1, 3'd2, IRO | PCL);              // JZ, zero
    fetch(4'hE, 0, 0); add(1, 4'hE, 0, 0, 3'd2, AO | OUTI);              // OUT
    fetch(4'hA, 0, 0); add(1, 4'hA, 0, 0, 3'd2, 14'h0);                  // unused
    // ADD with ena dropped at T3 for three cycles
    fetch(4'h2, 0, 0); add(1, 4'h2, 0, 0, 3'd2, IRO | MAR);
    add(0, 4'h2, 0, 0, 3'd3, 14'h0);
    add(0, 4'h2, 0, 0, 3'd3, 14'h0);
    add(0, 4'h2, 0, 0, 3'd3, 14'h0);
    add(1, 4'h2, 0, 0, 3'd3, RAMO | BI);
    add(1, 4'h2, 0, 0, 3'd4, ALUO | AI);
    fetch(4'h0, 0, 0);                                                   // wrapped to T0

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("T0 after release", 32'(step), 0);
    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) drive(vecs[i].ena, vecs[i].op, vecs[i].cf, vecs[i].zf);
      else begin
        ena = vecs[i].ena; opcode = vecs[i].op; cf = vecs[i].cf; zf = vecs[i].zf;
        #1;
      end
      check($sformatf("vec%0d step", i), 32'(step), 32'(vecs[i].exp_step));
      check($sformatf("vec%0d strobes", i), 32'(strobes()), 32'(vecs[i].exp_strb));
      check($sformatf("vec%0d halted", i), 32'(halted), 32'(vecs[i].exp_halt));
      check_bus($sformatf("vec%0d", i));
    end

    // HLT: finish current fetch context, then halt
    drive(1, 4'hF, 0, 0);   // T2 (vector table left us at T2 start? no: at T1 entry)
    // The last table entries were T0,T1 of a NOP-coded fetch; this cycle is T2.
    check("hlt T2 step", 32'(step), 2);
    check("hlt T2 strobes", 32'(strobes()), 0);
    check("hlt T2 not yet halted", 32'(halted), 0);
    for (int i = 0; i < 20; i++) begin
      drive(1, 4'hF, 0, 0);
      check($sformatf("halt%0d halted", i), 32'(halted), 1);
      check($sformatf("halt%0d step", i), 32'(step), 0);
      check($sformatf("halt%0d strobes", i), 32'(strobes()), 0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst clears halted", 32'(halted), 0);
    @(negedge clk);
    rst_n = 1'b1;
    opcode = 4'h1;
    #1;
    check("post-halt T0 strobes", 32'(strobes()), 32'(F0));

    // Reset asserted mid-T3 of LDA
    drive(1, 4'h1, 0, 0);
    check("lda T1 step", 32'(step), 1);
    drive(1, 4'h1, 0, 0);
    check("lda T2 strobes", 32'(strobes()), 32'(IRO | MAR));
    drive(1, 4'h1, 0, 0);
    check("lda T3 step", 32'(step), 3);
    check("lda T3 strobes", 32'(strobes()), 32'(RAMO | AI));
    #1 rst_n = 1'b0;
    #1;
    check("async rst step", 32'(step), 0);
    check("async rst strobes", 32'(strobes()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("after rst T0 strobes", 32'(strobes()), 32'(F0));
    drive(1, 4'h1, 0, 0);
    check("after rst T1 step", 32'(step), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
